alu_shift_seq: RTL
==================

// Module: alu_shift_seq
// PURPOSE
// - Sequences a shared 32-bit ALU for the core using a valid/ready request/response handshake.
// - Add, sub and compares complete in 1 or 2 execute cycles.
// - Shifts run iteratively (4-bit and/or 1-bit steps) instead of through a barrel shifter.
// - Sits between decode/issue and writeback; exactly one operation is in flight at a time.
// PARAMETERS
// - TWO_STAGE_SHIFT  1  1: step by 4 while count>=4, then by 1; 0: step by 1 only
// - TWO_CYCLE_ALU    0  1: add/sub/compare take one extra EXEC cycle before DONE
// PORTS
// - clk        in   1   clock, rising edge
// - resetn     in   1   asynchronous active-low reset
// - req_valid  in   1   request present
// - req_ready  out  1   block can accept; equals (state==IDLE)
// - req_op     in   3   0 ADD, 1 SUB, 2 SLL, 3 SRL, 4 SRA, 5 EQ, 6 LTS, 7 LTU
// - req_op1    in   32  operand 1 (shift source)
// - req_op2    in   32  operand 2 (shift amount = req_op2[4:0])
// - flush      in   1   abort current operation, no response
// - rsp_valid  out  1   result available
// - rsp_ready  in   1   consumer takes result
// - rsp_data   out  32  result; compare ops give {31'b0,cmp}
// - rsp_cmp    out  1   compare result (0 for non-compare ops)
// - busy       out  1   state!=IDLE
// - op_count   out  32  count of completed responses, wraps 2^32-1 -> 0
// BEHAVIOUR
// - Reset values (async, while resetn=0):
//   - state=IDLE; rsp_valid=0; rsp_data=0; rsp_cmp=0; op_count=0.
//   - Internal shift count and operand registers = 0.
// - FSM states: IDLE, EXEC, SHIFT, DONE.
// - IDLE: accept on req_valid&&req_ready; latch op, op1, op2[4:0].
//   - Shift op -> SHIFT.
//   - Other op, TWO_CYCLE_ALU=0 -> result registered, DONE.
//   - Other op, TWO_CYCLE_ALU=1 -> EXEC, then DONE with result.
// - SHIFT, count!=0: per cycle, if TWO_STAGE_SHIFT && count>=4 then shift by 4, count-=4;
//   else shift by 1, count-=1.
//   - SLL/SRL fill with 0; SRA fills with op1[31].
// - SHIFT, count==0 -> DONE.
// - DONE: rsp_valid=1; rsp_data/rsp_cmp stable until rsp_ready.
//   - On rsp_valid&&rsp_ready -> IDLE, op_count+=1.
//   - req_ready rises the following cycle; no same-cycle response+accept.
// - Latency, accept edge T to first rsp_valid cycle:
//   - ALU ops: T+1 (TWO_CYCLE_ALU=0) or T+2 (TWO_CYCLE_ALU=1).
//   - Shifts: T+2+steps, where steps = n/4 + n%4 (two-stage) or n (single-stage).
// - Arithmetic: ADD/SUB mod 2^32; LTS signed, LTU unsigned; EQ full 32-bit compare.
// - op2[31:5] ignored for shifts.
// - flush (any state except IDLE): -> IDLE next cycle, rsp_valid=0, op_count unchanged.
//   - flush in DONE with rsp_ready=1 same cycle: flush wins, no count.
//   - flush in IDLE: ignored; a same-cycle request is still accepted.
// - resetn low mid-operation: immediate return to reset values; no response ever issued.
// - req_* ignored while req_ready=0; the latched operands are unaffected.
// TESTING
// - ADD 0xFFFFFFFF+1, rsp_ready=1 -> rsp_data=0 at T+1, op_count=1.
// - SUB 5-7 -> rsp_data=0xFFFFFFFE.
// - LTS 0x80000000 vs 1 -> rsp_cmp=1.
// - LTU 0x80000000 vs 1 -> rsp_cmp=0.
// - SRA 0x80000000 by 31, TWO_STAGE_SHIFT=1 -> rsp_data=0xFFFFFFFF, rsp_valid at T+12.
//   - Same op with TWO_STAGE_SHIFT=0 -> rsp_valid at T+33.
// - SLL 0x1 by 0 -> rsp_data=1 at T+2.
// - SRL 0xF0 by 5 -> 0x7 at T+4.
// - Hold rsp_ready=0 for 10 cycles after DONE -> rsp_valid/rsp_data stable, req_ready=0.
//   - Release -> req_ready=1 next cycle.
// - flush at 3rd SHIFT cycle -> no rsp_valid, IDLE next cycle, op_count unchanged.
//   - resetn pulsed low mid-SHIFT -> all outputs at reset values.

Source files
------------

// File: rtl/alu_shift_seq.sv
// alu_shift_seq: one-at-a-time ALU sequencer for the core.
// Add/sub/compare finish in one or two execute cycles.
// Shifts are iterated in 4-bit and/or 1-bit steps instead of using a barrel shifter.
// A valid/ready request port feeds the block and a valid/ready response port drains it.
module alu_shift_seq #(
    parameter int TWO_STAGE_SHIFT = 1,  // 1: step by 4 while count>=4, then by 1
    parameter int TWO_CYCLE_ALU   = 0   // 1: add/sub/compare spend one EXEC cycle
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_op1,
    input  logic [31:0] req_op2,
    input  logic        flush,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic        rsp_cmp,
    output logic        busy,
    output logic [31:0] op_count
);

    // FSM encoding
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_EXEC  = 2'd1;
    localparam logic [1:0] S_SHIFT = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    // Operation encoding
    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_SLL = 3'd2;
    localparam logic [2:0] OP_SRL = 3'd3;
    localparam logic [2:0] OP_SRA = 3'd4;
    localparam logic [2:0] OP_EQ  = 3'd5;
    localparam logic [2:0] OP_LTS = 3'd6;
    localparam logic [2:0] OP_LTU = 3'd7;

    logic [1:0]  state_q, state_d;
    logic [2:0]  op_q, op_d;
    logic [31:0] op1_q, op1_d;
    logic [31:0] op2_q, op2_d;
    logic [31:0] shift_q, shift_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] rsp_data_q, rsp_data_d;
    logic        rsp_cmp_q, rsp_cmp_d;
    logic [31:0] op_count_q, op_count_d;

    function automatic logic is_shift(input logic [2:0] op);
        return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
    endfunction

    // ------------------------------------------------------------------
    // ALU datapath. In IDLE it works directly on the request so the
    // single-cycle variant can register its result at the accept edge;
    // in EXEC it works on the latched operands.
    // ------------------------------------------------------------------
    logic [2:0]  alu_op;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [31:0] alu_res;
    logic        alu_cmp;

    // Select ALU operands: live request while idle, latched copy otherwise
    always_comb begin
        if (state_q == S_IDLE) begin
            alu_op = req_op;
            alu_a  = req_op1;
            alu_b  = req_op2;
        end else begin
            alu_op = op_q;
            alu_a  = op1_q;
            alu_b  = op2_q;
        end
    end

    // Compute add/sub/compare result; compares return {31'b0, cmp}
    always_comb begin
        alu_cmp = 1'b0;
        alu_res = 32'd0;
        case (alu_op)
            OP_ADD: alu_res = alu_a + alu_b;
            OP_SUB: alu_res = alu_a - alu_b;
            OP_EQ:  alu_cmp = (alu_a == alu_b);
            OP_LTS: alu_cmp = ($signed(alu_a) < $signed(alu_b));
            OP_LTU: alu_cmp = (alu_a < alu_b);
            default: alu_res = 32'd0;
        endcase
        if ((alu_op == OP_EQ) || (alu_op == OP_LTS) || (alu_op == OP_LTU)) begin
            alu_res = {31'd0, alu_cmp};
        end
    end

    // ------------------------------------------------------------------
    // Iterative shifter: per-bit wiring of the 1-bit and 4-bit step
    // candidates. Right shifts fill with the original sign bit for SRA
    // and with zero for SRL.
    // ------------------------------------------------------------------
    logic        fill_bit;
    logic        step4;
    logic [31:0] sll1, sll4, sr1, sr4;

    assign fill_bit = (op_q == OP_SRA) ? op1_q[31] : 1'b0;

    generate
        if (TWO_STAGE_SHIFT != 0) begin : g_two_stage
            assign step4 = (cnt_q >= 5'd4);
        end else begin : g_one_stage
            assign step4 = 1'b0;
        end
    endgenerate

    genvar gi;
    generate
        for (gi = 0; gi < 32; gi++) begin : g_step
            if (gi >= 1) begin : g_l1
                assign sll1[gi] = shift_q[gi-1];
            end else begin : g_l1z
                assign sll1[gi] = 1'b0;
            end
            if (gi >= 4) begin : g_l4
                assign sll4[gi] = shift_q[gi-4];
            end else begin : g_l4z
                assign sll4[gi] = 1'b0;
            end
            if (gi <= 30) begin : g_r1
                assign sr1[gi] = shift_q[gi+1];
            end else begin : g_r1f
                assign sr1[gi] = fill_bit;
            end
            if (gi <= 27) begin : g_r4
                assign sr4[gi] = shift_q[gi+4];
            end else begin : g_r4f
                assign sr4[gi] = fill_bit;
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    // Sequence IDLE -> (EXEC | SHIFT) -> DONE -> IDLE, with flush override
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        op1_d      = op1_q;
        op2_d      = op2_q;
        shift_d    = shift_q;
        cnt_d      = cnt_q;
        rsp_data_d = rsp_data_q;
        rsp_cmp_d  = rsp_cmp_q;
        op_count_d = op_count_q;

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    op_d    = req_op;
                    op1_d   = req_op1;
                    op2_d   = req_op2;
                    shift_d = req_op1;
                    cnt_d   = req_op2[4:0];
                    if (is_shift(req_op)) begin
                        state_d = S_SHIFT;
                    end else if (TWO_CYCLE_ALU != 0) begin
                        state_d = S_EXEC;
                    end else begin
                        state_d    = S_DONE;
                        rsp_data_d = alu_res;
                        rsp_cmp_d  = alu_cmp;
                    end
                end
            end
            S_EXEC: begin
                state_d    = S_DONE;
                rsp_data_d = alu_res;
                rsp_cmp_d  = alu_cmp;
            end
            S_SHIFT: begin
                if (cnt_q == 5'd0) begin
                    state_d    = S_DONE;
                    rsp_data_d = shift_q;
                    rsp_cmp_d  = 1'b0;
                end else if (step4) begin
                    shift_d = (op_q == OP_SLL) ? sll4 : sr4;
                    cnt_d   = cnt_q - 5'd4;
                end else begin
                    shift_d = (op_q == OP_SLL) ? sll1 : sr1;
                    cnt_d   = cnt_q - 5'd1;
                end
            end
            S_DONE: begin
                if (rsp_ready) begin
                    state_d    = S_IDLE;
                    op_count_d = op_count_q + 32'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // An abort drops the operation without a response or count;
        // it has no effect while idle, so a same-cycle request still lands.
        if (flush && (state_q != S_IDLE)) begin
            state_d    = S_IDLE;
            op_count_d = op_count_q;
        end
    end

    // State and datapath registers, cleared asynchronously by resetn
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= S_IDLE;
            op_q       <= 3'd0;
            op1_q      <= 32'd0;
            op2_q      <= 32'd0;
            shift_q    <= 32'd0;
            cnt_q      <= 5'd0;
            rsp_data_q <= 32'd0;
            rsp_cmp_q  <= 1'b0;
            op_count_q <= 32'd0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            op1_q      <= op1_d;
            op2_q      <= op2_d;
            shift_q    <= shift_d;
            cnt_q      <= cnt_d;
            rsp_data_q <= rsp_data_d;
            rsp_cmp_q  <= rsp_cmp_d;
            op_count_q <= op_count_d;
        end
    end

    assign req_ready = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign rsp_valid = (state_q == S_DONE);
    assign rsp_data  = rsp_data_q;
    assign rsp_cmp   = rsp_cmp_q;
    assign op_count  = op_count_q;

endmodule
